mem_bus_sequencer: RTL

//   Owns the single shared 8-bit external bus and arbitrates it between two

---
 rtl/mem_bus_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer: owns the shared external bus and arbitrates it between
// instruction fetch (ROM) and load/store (RAM). Each access runs as
// ADDR -> WAIT (WAIT_CYCLES, skipped at 0) -> DATA -> RESP, then back to IDLE.
// RAM wins simultaneous requests. All pin-facing outputs are registered.
// Optional feature macro: BUS_READY_EN adds a bus_ready input that stretches
// the DATA phase until the external device is ready.
module mem_bus_sequencer #(
  parameter int BITS        = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic [BITS-1:0] fetch_addr,
  output logic            fetch_done,
  output logic [BITS-1:0] fetch_data,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [BITS-1:0] mem_addr,
  input  logic [BITS-1:0] mem_wdata,
  output logic            mem_done,
  output logic [BITS-1:0] mem_rdata,
  input  logic [BITS-1:0] data_in,
`ifdef BUS_READY_EN
  input  logic            bus_ready,
`endif
  output logic [BITS-1:0] data_out,
  output logic            rom_ram,
  output logic            addr_data,
  output logic            bus_we,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_DATA,
    S_RESP
  } state_e;

  // WAIT exits when the counter reaches zero, so it is loaded with N-1.
  localparam logic [2:0] WAIT_LOAD = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e          state_q, state_d;
  logic            grant_ram_q, grant_ram_d;
  logic            we_q, we_d;
  logic [BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0] wdata_q, wdata_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [BITS-1:0] fetch_data_q, fetch_data_d;
  logic [BITS-1:0] mem_rdata_q, mem_rdata_d;
  logic [BITS-1:0] data_out_q, data_out_d;
  logic            rom_ram_q, rom_ram_d;
  logic            addr_data_q, addr_data_d;
  logic            bus_we_q, bus_we_d;
  logic            busy_q, busy_d;
  logic            fetch_done_q, fetch_done_d;
  logic            mem_done_q, mem_done_d;
  logic            rdy;

`ifdef BUS_READY_EN
  assign rdy = bus_ready;
`else
  assign rdy = 1'b1;
`endif

  // Next-state, request latching, read sampling, and next-cycle pin values.
  always_comb begin
    state_d      = state_q;
    grant_ram_d  = grant_ram_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    fetch_data_d = fetch_data_q;
    mem_rdata_d  = mem_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          state_d     = S_ADDR;
          grant_ram_d = 1'b1;
          we_d        = mem_we;
          addr_d      = mem_addr;
          wdata_d     = mem_wdata;
        end else if (fetch_req) begin
          state_d     = S_ADDR;
          grant_ram_d = 1'b0;
          we_d        = 1'b0;
          addr_d      = fetch_addr;
          wdata_d     = '0;
        end
      end
      S_ADDR: begin
        if (WAIT_CYCLES == 0) begin
          state_d = S_DATA;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_DATA: begin
        // DATA repeats (holding the bus) until the device is ready.
        if (rdy) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (grant_ram_q) mem_rdata_d  = data_in;
            else             fetch_data_d = data_in;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so derive them from the state being entered.
    busy_d       = (state_d != S_IDLE);
    rom_ram_d    = (state_d != S_IDLE) && grant_ram_d;
    addr_data_d  = (state_d == S_ADDR);
    bus_we_d     = (state_d == S_DATA) && we_d;
    fetch_done_d = (state_d == S_RESP) && !grant_ram_d;
    mem_done_d   = (state_d == S_RESP) && grant_ram_d;
    if (state_d == S_ADDR)              data_out_d = addr_d;
    else if (state_d == S_DATA && we_d) data_out_d = wdata_d;
    else                                data_out_d = '0;
  end

  // FSM state, latched request and registered outputs; reset aborts at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_ram_q  <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 3'd0;
      fetch_data_q <= '0;
      mem_rdata_q  <= '0;
      data_out_q   <= '0;
      rom_ram_q    <= 1'b0;
      addr_data_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      fetch_done_q <= 1'b0;
      mem_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_ram_q  <= grant_ram_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      fetch_data_q <= fetch_data_d;
      mem_rdata_q  <= mem_rdata_d;
      data_out_q   <= data_out_d;
      rom_ram_q    <= rom_ram_d;
      addr_data_q  <= addr_data_d;
      bus_we_q     <= bus_we_d;
      busy_q       <= busy_d;
      fetch_done_q <= fetch_done_d;
      mem_done_q   <= mem_done_d;
    end
  end

  assign fetch_done = fetch_done_q;
  assign fetch_data = fetch_data_q;
  assign mem_done   = mem_done_q;
  assign mem_rdata  = mem_rdata_q;
  assign data_out   = data_out_q;
  assign rom_ram    = rom_ram_q;
  assign addr_data  = addr_data_q;
  assign bus_we     = bus_we_q;
  assign busy       = busy_q;

endmodule
